// File: rtl/mouse_cursor_ctrl_pkg.sv
// Shared constants for the mouse cursor path: screen size defaults, assembler
// state encoding and PS/2 movement packet bit positions.
package mouse_cursor_ctrl_pkg;

    localparam int unsigned H_RES_DEF = 640;
    localparam int unsigned V_RES_DEF = 480;

    // Bit positions inside the first (status) byte of a movement packet.
    localparam int unsigned BL   = 0;
    localparam int unsigned BR   = 1;
    localparam int unsigned SYNC = 3;
    localparam int unsigned XS   = 4;
    localparam int unsigned YS   = 5;
    localparam int unsigned XOV  = 6;
    localparam int unsigned YOV  = 7;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        APPLY   = 2'd3
    } state_t;

endpackage

// File: rtl/cursor_clamp.sv
// One cursor axis: signed add of a delta to the current position, clamped to
// the range [0, LIMIT].
module cursor_clamp #(
    parameter int unsigned LIMIT = 639
) (
    input  logic        [9:0] pos,
    input  logic signed [9:0] delta,
    output logic        [9:0] result
);

    localparam logic signed [10:0] LIM = 11'(LIMIT);

    logic signed [10:0] sum;

    always_comb begin
        sum = $signed({1'b0, pos}) + $signed({delta[9], delta});
        if (sum < 11'sd0) begin
            result = '0;
        end else if (sum > LIM) begin
            result = LIM[9:0];
        end else begin
            result = sum[9:0];
        end
    end

endmodule

// File: rtl/mouse_cursor_ctrl.sv
// Assembles PS/2 movement packets into a clamped cursor position and publishes
// it to the display only at frame start.
module mouse_cursor_ctrl
    import mouse_cursor_ctrl_pkg::*;
#(
    parameter int unsigned H_RES   = H_RES_DEF,
    parameter int unsigned V_RES   = V_RES_DEF,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    input  logic       frame_tick,
    output logic [9:0] mouse_x,
    output logic [9:0] mouse_y,
    output logic       btn_l,
    output logic       btn_r,
    output logic       pkt_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [9:0] X_MID = 10'(H_RES / 2);
    localparam logic [9:0] Y_MID = 10'(V_RES / 2);

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic [7:4]    b0_flags;
    logic [1:0]    b0_btn;
    logic [7:0]    dx_byte;
    logic [7:0]    dy_byte;
    logic [9:0]    pend_x;
    logic [9:0]    pend_y;
    logic          pend_bl;
    logic          pend_br;

    logic [8:0]        dx9;
    logic [8:0]        dy9;
    logic signed [9:0] delta_x;
    logic signed [9:0] delta_y;
    logic [9:0]        new_x;
    logic [9:0]        new_y;

    // Overflowed axes contribute nothing; PS/2 +y is up, screen +y is down.
    always_comb begin
        dx9     = b0_flags[XOV] ? 9'd0 : {b0_flags[XS], dx_byte};
        dy9     = b0_flags[YOV] ? 9'd0 : {b0_flags[YS], dy_byte};
        delta_x = $signed({dx9[8], dx9});
        delta_y = -$signed({dy9[8], dy9});
    end

    cursor_clamp #(
        .LIMIT(H_RES - 1)
    ) u_clamp_x (
        .pos   (pend_x),
        .delta (delta_x),
        .result(new_x)
    );

    cursor_clamp #(
        .LIMIT(V_RES - 1)
    ) u_clamp_y (
        .pos   (pend_y),
        .delta (delta_y),
        .result(new_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_B0;
            tmo_cnt  <= '0;
            b0_flags <= '0;
            b0_btn   <= '0;
            dx_byte  <= '0;
            dy_byte  <= '0;
            pend_x   <= X_MID;
            pend_y   <= Y_MID;
            pend_bl  <= 1'b0;
            pend_br  <= 1'b0;
            mouse_x  <= X_MID;
            mouse_y  <= Y_MID;
            btn_l    <= 1'b0;
            btn_r    <= 1'b0;
            pkt_err  <= 1'b0;
        end else begin
            pkt_err <= 1'b0;
            // Publish reads pending before any APPLY update in this cycle.
            if (frame_tick) begin
                mouse_x <= pend_x;
                mouse_y <= pend_y;
                btn_l   <= pend_bl;
                btn_r   <= pend_br;
            end
            unique case (state)
                WAIT_B0: begin
                    if (rx_done_tick) begin
                        if (rx_data[SYNC]) begin
                            b0_flags <= rx_data[7:4];
                            b0_btn   <= rx_data[1:0];
                            tmo_cnt  <= '0;
                            state    <= WAIT_B1;
                        end else begin
                            pkt_err <= 1'b1;
                        end
                    end
                end
                WAIT_B1, WAIT_B2: begin
                    if (rx_done_tick) begin
                        tmo_cnt <= '0;
                        if (state == WAIT_B1) begin
                            dx_byte <= rx_data;
                            state   <= WAIT_B2;
                        end else begin
                            dy_byte <= rx_data;
                            state   <= APPLY;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt <= '0;
                        pkt_err <= 1'b1;
                        state   <= WAIT_B0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                APPLY: begin
                    pend_x  <= new_x;
                    pend_y  <= new_y;
                    pend_bl <= b0_btn[BL];
                    pend_br <= b0_btn[BR];
                    state   <= WAIT_B0;
                end
                default: state <= WAIT_B0;
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_cursor_ctrl.sv
// Directed bench for mouse_cursor_ctrl: a packet-level reference model is
// compared against the DUT every cycle, plus literal checkpoints.
module tb_mouse_cursor_ctrl;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done_tick = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic       btn_l;
    logic       btn_r;
    logic       pkt_err;

    mouse_cursor_ctrl #(
        .H_RES  (640),
        .V_RES  (480),
        .TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_done_tick(rx_done_tick),
        .frame_tick  (frame_tick),
        .mouse_x     (mouse_x),
        .mouse_y     (mouse_y),
        .btn_l       (btn_l),
        .btn_r       (btn_r),
        .pkt_err     (pkt_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;

    // Reference model state: pending/published cursor, packet bytes so far.
    int       m_px, m_py, m_ox, m_oy;
    bit       m_pbl, m_pbr, m_obl, m_obr, m_err;
    int       m_nbytes, m_idle;
    bit       m_apply;
    int       m_nx, m_ny;
    bit       m_nbl, m_nbr;
    bit [7:0] m_b0, m_dx;

    function automatic int clampi(int v, int lim);
        if (v < 0) return 0;
        if (v > lim) return lim;
        return v;
    endfunction

    function automatic int delta9(bit sign, bit [7:0] mag, bit ovf);
        if (ovf) return 0;
        return sign ? int'(mag) - 256 : int'(mag);
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(bit r, bit rd, bit [7:0] d, bit ft);
        if (r) begin
            m_px = 320; m_py = 240; m_pbl = 0; m_pbr = 0;
            m_ox = 320; m_oy = 240; m_obl = 0; m_obr = 0;
            m_err = 0; m_nbytes = 0; m_idle = 0; m_apply = 0;
            return;
        end
        m_err = 0;
        if (ft) begin
            m_ox = m_px; m_oy = m_py; m_obl = m_pbl; m_obr = m_pbr;
        end
        if (m_apply) begin
            // A byte arriving while the packet is being applied is dropped.
            m_px = m_nx; m_py = m_ny; m_pbl = m_nbl; m_pbr = m_nbr;
            m_apply = 0;
        end else if (rd) begin
            m_idle = 0;
            if (m_nbytes == 0) begin
                if (d[3]) begin
                    m_b0 = d;
                    m_nbytes = 1;
                end else begin
                    m_err = 1;
                end
            end else if (m_nbytes == 1) begin
                m_dx = d;
                m_nbytes = 2;
            end else begin
                m_nx = clampi(m_px + delta9(m_b0[4], m_dx, m_b0[6]), 639);
                m_ny = clampi(m_py - delta9(m_b0[5], d, m_b0[7]), 479);
                m_nbl = m_b0[0];
                m_nbr = m_b0[1];
                m_apply = 1;
                m_nbytes = 0;
            end
        end else if (m_nbytes != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_err = 1;
                m_nbytes = 0;
                m_idle = 0;
            end
        end
    endtask

    task automatic cycle(bit r, bit rd, bit [7:0] d, bit ft);
        reset = r;
        rx_done_tick = rd;
        rx_data = d;
        frame_tick = ft;
        @(posedge clk);
        model_step(r, rd, d, ft);
        @(negedge clk);
        chk("mouse_x", int'(mouse_x), m_ox);
        chk("mouse_y", int'(mouse_y), m_oy);
        chk("btn_l", int'(btn_l), int'(m_obl));
        chk("btn_r", int'(btn_r), int'(m_obr));
        chk("pkt_err", int'(pkt_err), int'(m_err));
        if (pkt_err) err_cnt++;
        reset = 1'b0;
        rx_done_tick = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic send(bit [7:0] b);
        cycle(0, 1, b, 0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0);
    endtask

    task automatic frame();
        cycle(0, 0, 8'h00, 1);
    endtask

    task automatic packet(bit [7:0] a, bit [7:0] b, bit [7:0] c);
        send(a); send(b); send(c); idle(2);
    endtask

    initial begin
        cycle(1, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0);
        idle(2);
        chk("reset_x", int'(mouse_x), 320);
        chk("reset_y", int'(mouse_y), 240);
        frame(); idle(1);
        chk("frame0_x", int'(mouse_x), 320);
        chk("frame0_btn", int'({btn_l, btn_r}), 0);

        // dx=+10, dy=+5 (up): held back until the frame tick.
        packet(8'h08, 8'h0A, 8'h05);
        idle(3);
        chk("no_publish_x", int'(mouse_x), 320);
        frame(); idle(1);
        chk("pkt1_x", int'(mouse_x), 330);
        chk("pkt1_y", int'(mouse_y), 235);

        // dx=-10, dy=-5, left button.
        packet(8'h39, 8'hF6, 8'hFB);
        frame(); idle(1);
        chk("pkt2_x", int'(mouse_x), 320);
        chk("pkt2_y", int'(mouse_y), 240);
        chk("pkt2_bl", int'(btn_l), 1);

        // Two dx=-256 packets clamp x at 0 (only the final value is published).
        packet(8'h18, 8'h00, 8'h00);
        packet(8'h18, 8'h00, 8'h00);
        frame(); idle(1);
        chk("clamp_x0", int'(mouse_x), 0);
        chk("clamp_bl", int'(btn_l), 0);

        // dy=-256 moves down past the bottom edge.
        packet(8'h28, 8'h00, 8'h00);
        frame(); idle(1);
        chk("clamp_ymax", int'(mouse_y), 479);

        send(8'h00); idle(2);
        chk("sync_err", err_cnt, 1);

        send(8'h08); send(8'h05); idle(TMO + 5);
        chk("tmo_err", err_cnt, 2);
        frame(); idle(1);
        chk("tmo_x", int'(mouse_x), 0);
        chk("tmo_y", int'(mouse_y), 479);

        packet(8'h08, 8'h01, 8'h01);
        frame(); idle(1);
        chk("after_tmo_x", int'(mouse_x), 1);
        chk("after_tmo_y", int'(mouse_y), 478);

        // X overflow with both buttons; frame tick lands on the APPLY cycle.
        send(8'h4B); send(8'h7F); send(8'h00);
        frame(); idle(1);
        chk("coinc_old_bl", int'(btn_l), 0);
        chk("coinc_old_br", int'(btn_r), 0);
        frame(); idle(1);
        chk("ovf_x", int'(mouse_x), 1);
        chk("ovf_y", int'(mouse_y), 478);
        chk("ovf_btn", int'({btn_l, btn_r}), 3);

        // A byte during APPLY is lost; the next 0x00 is then a sync error.
        send(8'h08); send(8'h00); send(8'h00); send(8'h08);
        send(8'h00); idle(2);
        chk("apply_drop_err", err_cnt, 3);

        // Reset mid-packet, then a full packet applies from the centre.
        send(8'h08); send(8'h0A);
        cycle(1, 0, 8'h00, 0);
        chk("midrst_x", int'(mouse_x), 320);
        chk("midrst_y", int'(mouse_y), 240);
        packet(8'h08, 8'h0A, 8'h05);
        frame(); idle(1);
        chk("midrst_pkt_x", int'(mouse_x), 330);
        chk("midrst_pkt_y", int'(mouse_y), 235);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
